multdiv_stall_unit: RTL and testbench
=====================================

# multdiv_stall_unit

Iterative 32-bit signed multiply/divide unit at the execute end of the decode/execute pipeline latch. It consumes the operand values that latch presents and drives a stall back to the latch enables while an operation is in flight. One-cycle start pulses launch an operation. The unit returns a 32-bit result, an exception flag and a one-cycle ready pulse.

## Interface
- Parameters: none; datapath fixed at 32 bits.
- clock  input  1  rising-edge clock.
- resn  input  1  asynchronous, active-low reset.
- ctrl_mult  input  1  one-cycle pulse: start multiply of operandA × operandB.
- ctrl_div  input  1  one-cycle pulse: start divide of operandA ÷ operandB.
- operandA  input  32  signed operand (valA from the latch); sampled only on the start cycle.
- operandB  input  32  signed operand (valB from the latch); sampled only on the start cycle.
- data_result  output  32  signed result; valid while data_resultRDY = 1, held until the next start.
- data_exception  output  1  error flag; valid while data_resultRDY = 1, held until the next start.
- data_resultRDY  output  1  one-cycle pulse marking the completion cycle.
- stall  output  1  deasserts the upstream latch enables (en = ~stall) while busy.

## Operation
- States: IDLE, MULT, DIV, DONE.
- IDLE: on ctrl_mult, capture the operands, clear the 5-bit iteration counter, go to MULT. On ctrl_div, do the same and go to DIV.
- ctrl_mult and ctrl_div together: multiply wins; the divide request is dropped.
- Start pulses seen in MULT, DIV or DONE are ignored. Captured operands do not change until the next accepted start.
- MULT: radix-2 Booth multiply on a 65-bit {acc[31:0], multiplier[31:0], q-1} product register. Arithmetic right shift each cycle; 32 iterations.
  - data_result = product[31:0].
  - data_exception = 1 when the 64-bit product is not the sign extension of bit 31 (signed overflow).
- DIV: restoring division on the operand magnitudes; one quotient bit per cycle; 32 iterations.
  - Quotient sign = sign(A) XOR sign(B). Truncate toward zero. Remainder is discarded.
  - B = 0: data_exception = 1 and data_result = 0. The unit still runs the full 32 cycles.
  - A = 0x80000000 and B = 0xFFFFFFFF: data_result = 0x80000000, data_exception = 1.
- After iteration 31 (counter = 31), go to DONE. DONE registers the result and exception, pulses data_resultRDY, then returns to IDLE.
- An accepted start in the cycle right after DONE launches a new operation normally.
- Reset (resn = 0, any time, including mid-operation):
  - State goes to IDLE, counter to 0.
  - data_result = 0, data_exception = 0, data_resultRDY = 0, stall = 0.
  - Any in-flight operation is discarded.

## Timing
- Cycle 0: the start pulse is sampled at the end of cycle 0.
- Iterations run in cycles 1–32.
- data_resultRDY is high in cycle 33 only. Latency from start to ready is 33 cycles.
- stall is combinational: stall = (state ≠ IDLE and state ≠ DONE) or (state = IDLE and (ctrl_mult or ctrl_div)).
  - High in cycles 0–32.
  - Low in cycle 33, so the latch advances on the same edge that the result is consumed.
- data_result and data_exception are registered. They change only at the DONE transition and on reset.
- No combinational path from the operand inputs to any output.

## Test plan
- Reset mid-operation: start multiply 7 × 9, assert resn = 0 at cycle 10 → every output 0 immediately, no ready pulse ever appears; a new multiply 3 × 4 after reset gives result 12 at cycle 33.
- Multiply, signed and overflow cases:
  - 0xFFFFFFFD × 6 (−3 × 6) → result 0xFFFFFFEE (−18), exception 0, ready in cycle 33, stall high in cycles 0–32.
  - 0x10000 × 0x10000 → result 0, exception 1.
- Divide, normal and by zero:
  - −7 ÷ 2 → result 0xFFFFFFFD (−3), exception 0.
  - 100 ÷ 0 → result 0, exception 1, still ready in cycle 33.
- Divide overflow: 0x80000000 ÷ 0xFFFFFFFF → result 0x80000000, exception 1.
- Start collisions:
  - ctrl_mult and ctrl_div asserted together with 5 and 2 → multiply result 10.
  - A ctrl_div pulse at cycle 15 of a running multiply → ignored; exactly one ready pulse.
- Back-to-back operations: a divide launched in the cycle after ready (20 ÷ 4) → result 5 with ready 34 cycles after the first ready, and the previous result held in between.

Source files
------------

// File: rtl/multdiv_stall_unit.sv
// Iterative 32-bit signed multiply/divide unit with pipeline stall.
// Booth radix-2 multiply or restoring divide, 32 iterations, one-cycle ready pulse.
module multdiv_stall_unit (
  input  logic        clock,
  input  logic        resn,
  input  logic        ctrl_mult,
  input  logic        ctrl_div,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        stall
);

  typedef enum logic [1:0] {StIdle, StMult, StDiv, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [64:0] prod_q, prod_d;       // {acc, multiplier, q-1}
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] divisor_q, divisor_d; // divisor magnitude
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;         // dividend magnitude shifting out, quotient shifting in
  logic        q_neg_q, q_neg_d;
  logic        div_zero_q, div_zero_d;
  logic        div_ovf_q, div_ovf_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;

  logic        start_mult, start_div;
  logic [31:0] a_mag, b_mag;
  logic [32:0] acc_ext, mcand_ext, booth_sum;
  logic [64:0] booth_next;
  logic [32:0] div_shift, div_trial;
  logic [31:0] rem_next, quo_next;
  logic [31:0] quo_signed;

  assign start_mult = (state_q == StIdle) && ctrl_mult;
  assign start_div  = (state_q == StIdle) && ctrl_div && !ctrl_mult;

  assign a_mag = operandA[31] ? (32'd0 - operandA) : operandA;
  assign b_mag = operandB[31] ? (32'd0 - operandB) : operandB;

  // Accumulator is widened by one bit so that subtracting the most negative
  // multiplicand cannot wrap before the arithmetic shift.
  always_comb begin
    acc_ext   = {prod_q[64], prod_q[64:33]};
    mcand_ext = {mcand_q[31], mcand_q};
    unique case (prod_q[1:0])
      2'b01:   booth_sum = acc_ext + mcand_ext;
      2'b10:   booth_sum = acc_ext - mcand_ext;
      default: booth_sum = acc_ext;
    endcase
    booth_next = {booth_sum, prod_q[32:1]};
  end

  always_comb begin
    div_shift = {rem_q, quo_q[31]};
    div_trial = div_shift - {1'b0, divisor_q};
    if (!div_trial[32]) begin
      rem_next = div_trial[31:0];
      quo_next = {quo_q[30:0], 1'b1};
    end else begin
      rem_next = div_shift[31:0];
      quo_next = {quo_q[30:0], 1'b0};
    end
    quo_signed = q_neg_q ? (32'd0 - quo_next) : quo_next;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prod_d     = prod_q;
    mcand_d    = mcand_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    q_neg_d    = q_neg_q;
    div_zero_d = div_zero_q;
    div_ovf_d  = div_ovf_q;
    result_d   = result_q;
    exc_d      = exc_q;

    unique case (state_q)
      StIdle: begin
        if (start_mult) begin
          state_d = StMult;
          cnt_d   = 5'd0;
          prod_d  = {32'd0, operandA, 1'b0};
          mcand_d = operandB;
        end else if (start_div) begin
          state_d    = StDiv;
          cnt_d      = 5'd0;
          rem_d      = 32'd0;
          quo_d      = a_mag;
          divisor_d  = b_mag;
          q_neg_d    = operandA[31] ^ operandB[31];
          div_zero_d = (operandB == 32'd0);
          div_ovf_d  = (operandA == 32'h8000_0000) && (operandB == 32'hFFFF_FFFF);
        end
      end
      StMult: begin
        prod_d = booth_next;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d  = StDone;
          result_d = booth_next[32:1];
          exc_d    = booth_next[64:33] != {32{booth_next[32]}};
        end
      end
      StDiv: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d  = StDone;
          result_d = div_zero_q ? 32'd0 : quo_signed;
          exc_d    = div_zero_q | div_ovf_q;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resn) begin
    if (!resn) begin
      state_q    <= StIdle;
      cnt_q      <= 5'd0;
      prod_q     <= 65'd0;
      mcand_q    <= 32'd0;
      divisor_q  <= 32'd0;
      rem_q      <= 32'd0;
      quo_q      <= 32'd0;
      q_neg_q    <= 1'b0;
      div_zero_q <= 1'b0;
      div_ovf_q  <= 1'b0;
      result_q   <= 32'd0;
      exc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prod_q     <= prod_d;
      mcand_q    <= mcand_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      q_neg_q    <= q_neg_d;
      div_zero_q <= div_zero_d;
      div_ovf_q  <= div_ovf_d;
      result_q   <= result_d;
      exc_q      <= exc_d;
    end
  end

  // Stall drops in DONE so the latch advances on the edge that consumes the result.
  assign stall = (state_q == StMult) || (state_q == StDiv) ||
                 ((state_q == StIdle) && (ctrl_mult || ctrl_div));

  assign data_resultRDY = (state_q == StDone);
  assign data_result    = result_q;
  assign data_exception = exc_q;

endmodule

// File: tb/tb_multdiv_stall_unit.sv
// Directed bench for multdiv_stall_unit: latency, stall window, signed results,
// exceptions, start collisions, mid-operation reset and back-to-back operations.
module tb_multdiv_stall_unit;

  logic        clock = 1'b0;
  logic        resn = 1'b0;
  logic        ctrl_mult = 1'b0;
  logic        ctrl_div = 1'b0;
  logic [31:0] operandA = 32'd0;
  logic [31:0] operandB = 32'd0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        stall;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_res = 32'd0;
  logic        last_exc = 1'b0;

  multdiv_stall_unit dut (
    .clock          (clock),
    .resn           (resn),
    .ctrl_mult      (ctrl_mult),
    .ctrl_div       (ctrl_div),
    .operandA       (operandA),
    .operandB       (operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .stall          (stall)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; that cycle is cycle 0 of the operation.
  // Returns just after the edge that starts cycle 34.
  task automatic run_op(input logic m, input logic d, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r, input logic exp_e,
                        input int inject_div, input string tag);
    ctrl_mult = m;
    ctrl_div  = d;
    operandA  = a;
    operandB  = b;
    #1;
    check({tag, " stall c0"}, {31'd0, stall}, 32'd1);
    check({tag, " rdy c0"}, {31'd0, data_resultRDY}, 32'd0);
    for (int c = 1; c <= 33; c++) begin
      @(posedge clock);
      #1;
      ctrl_mult = 1'b0;
      ctrl_div  = (c == inject_div);
      operandA  = $urandom;
      operandB  = $urandom;
      #1;
      if (c <= 32) begin
        check($sformatf("%s stall c%0d", tag, c), {31'd0, stall}, 32'd1);
        check($sformatf("%s rdy c%0d", tag, c), {31'd0, data_resultRDY}, 32'd0);
        check($sformatf("%s hold res c%0d", tag, c), data_result, last_res);
        check($sformatf("%s hold exc c%0d", tag, c), {31'd0, data_exception},
              {31'd0, last_exc});
      end else begin
        check({tag, " rdy c33"}, {31'd0, data_resultRDY}, 32'd1);
        check({tag, " stall c33"}, {31'd0, stall}, 32'd0);
        check({tag, " result"}, data_result, exp_r);
        check({tag, " exception"}, {31'd0, data_exception}, {31'd0, exp_e});
      end
    end
    ctrl_div = 1'b0;
    @(posedge clock);
    #1;
    check({tag, " rdy c34"}, {31'd0, data_resultRDY}, 32'd0);
    check({tag, " held res c34"}, data_result, exp_r);
    last_res = exp_r;
    last_exc = exp_e;
  endtask

  task automatic quiet_cycles(input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      @(posedge clock);
      #2;
      check($sformatf("%s no rdy %0d", tag, c), {31'd0, data_resultRDY}, 32'd0);
      check($sformatf("%s no stall %0d", tag, c), {31'd0, stall}, 32'd0);
    end
  endtask

  initial begin
    #2;
    check("reset result", data_result, 32'd0);
    check("reset exc", {31'd0, data_exception}, 32'd0);
    check("reset rdy", {31'd0, data_resultRDY}, 32'd0);
    check("reset stall", {31'd0, stall}, 32'd0);
    @(posedge clock);
    @(posedge clock);
    #1 resn = 1'b1;
    @(posedge clock);
    #1;

    run_op(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd6, 32'hFFFF_FFEE, 1'b0, -1, "mul -3*6");

    // Reset at cycle 10 of a 7*9 multiply.
    ctrl_mult = 1'b1;
    operandA  = 32'd7;
    operandB  = 32'd9;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clock);
      #1 ctrl_mult = 1'b0;
    end
    resn = 1'b0;
    #1;
    check("midrst result", data_result, 32'd0);
    check("midrst exc", {31'd0, data_exception}, 32'd0);
    check("midrst rdy", {31'd0, data_resultRDY}, 32'd0);
    check("midrst stall", {31'd0, stall}, 32'd0);
    @(posedge clock);
    #1 resn = 1'b1;
    last_res = 32'd0;
    last_exc = 1'b0;
    quiet_cycles(40, "after rst");
    run_op(1'b1, 1'b0, 32'd3, 32'd4, 32'd12, 1'b0, -1, "mul 3*4");

    run_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, -1, "mul ovf");
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, -1, "mul min*-1");
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, -1, "div -7/2");
    run_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 1'b0, -1, "div -100/-7");
    run_op(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, -1, "div 100/-7");
    run_op(1'b0, 1'b1, 32'd100, 32'd0, 32'd0, 1'b1, -1, "div by 0");
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, -1, "div ovf");
    run_op(1'b1, 1'b1, 32'd5, 32'd2, 32'd10, 1'b0, -1, "both starts");
    run_op(1'b1, 1'b0, 32'd1000, 32'hFFFF_FFFD, 32'hFFFF_F448, 1'b0, 15, "div ignored");
    quiet_cycles(10, "one rdy");

    // Back-to-back: second start lands in the cycle right after ready.
    run_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd1, 1'b1, -1, "mul max*max");
    run_op(1'b0, 1'b1, 32'd20, 32'd4, 32'd5, 1'b0, -1, "b2b div 20/4");
    quiet_cycles(3, "end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
